// File: rtl/ws_pixel_serializer.sv
// Pixel word serializer for an LED bit-timing encoder: one-word hold buffer with
// valid/ready intake, one bit per en tick, per-frame pixel counting and underrun flagging.
module ws_pixel_serializer #(
    parameter int W         = 24,
    parameter bit MSB_FIRST = 1'b1,
    parameter int PIXELS    = 8,
    parameter int CW        = $clog2(W + 1),
    parameter int PW        = $clog2(PIXELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out,
    output logic          out_valid,
    output logic          word_done,
    output logic          frame_done,
    output logic          underrun,
    output logic [CW-1:0] bits_left_dbg,
    output logic [PW-1:0] pixel_cnt_dbg
);

    logic [W-1:0]  r_hold;
    logic          r_hold_valid;
    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_bits_left;
    logic [PW-1:0] r_pixel_cnt;
    logic          r_out;
    logic          r_out_valid;
    logic          r_word_done;
    logic          r_frame_done;
    logic          r_underrun;

    logic          w_accept;
    logic          w_shift;
    logic          w_load;
    logic          w_last;
    logic          w_frame_end;
    logic          w_load_bit;
    logic          w_shift_bit;
    logic [W-1:0]  w_hold_adv;
    logic [W-1:0]  w_shift_adv;

    assign in_ready    = ~r_hold_valid;
    assign w_accept    = in_valid & ~r_hold_valid;
    assign w_shift     = en && (r_bits_left != '0);
    assign w_load      = en && (r_bits_left == '0) && r_hold_valid;
    assign w_last      = w_shift && (r_bits_left == CW'(1));
    assign w_frame_end = (r_pixel_cnt == PW'(PIXELS - 1));

    // The shifter always presents the next bit at the same end; direction is
    // folded into which end is emitted and which way the word advances.
    assign w_load_bit  = MSB_FIRST ? r_hold[W-1]  : r_hold[0];
    assign w_shift_bit = MSB_FIRST ? r_shift[W-1] : r_shift[0];
    assign w_hold_adv  = MSB_FIRST ? {r_hold[W-2:0], 1'b0}  : {1'b0, r_hold[W-1:1]};
    assign w_shift_adv = MSB_FIRST ? {r_shift[W-2:0], 1'b0} : {1'b0, r_shift[W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too so a discarded word can never leak out later.
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bits_left  <= '0;
            r_pixel_cnt  <= '0;
            r_out        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;

            // Accept and load are exclusive: accept needs an empty hold, load a full one.
            if (w_accept) begin
                r_hold       <= in_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end

            if (w_shift) begin
                r_out       <= w_shift_bit;
                r_out_valid <= 1'b1;
                r_shift     <= w_shift_adv;
                r_bits_left <= r_bits_left - CW'(1);
                if (w_last) begin
                    r_word_done <= 1'b1;
                    if (w_frame_end) begin
                        r_frame_done <= 1'b1;
                        r_pixel_cnt  <= '0;
                    end else begin
                        r_pixel_cnt <= r_pixel_cnt + PW'(1);
                    end
                end
            end else if (w_load) begin
                r_out       <= w_load_bit;
                r_out_valid <= 1'b1;
                r_shift     <= w_hold_adv;
                r_bits_left <= CW'(W - 1);
            end else if (en) begin
                // Starved tick: mid-frame it is an underrun, the frame itself continues.
                r_out       <= 1'b0;
                r_out_valid <= 1'b0;
                if (r_pixel_cnt != '0) begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign out           = r_out;
    assign out_valid     = r_out_valid;
    assign word_done     = r_word_done;
    assign frame_done    = r_frame_done;
    assign underrun      = r_underrun;
    assign bits_left_dbg = r_bits_left;
    assign pixel_cnt_dbg = r_pixel_cnt;

endmodule

// File: tb/tb_ws_pixel_serializer.sv
// Directed bench for ws_pixel_serializer: a 24-bit MSB-first, 2-pixel instance and an
// 8-bit LSB-first instance, checked against hand-derived bit sequences.
module tb_ws_pixel_serializer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_bit;
    logic        out_valid;
    logic        word_done;
    logic        frame_done;
    logic        underrun;
    logic [4:0]  bits_left;
    logic [1:0]  pixel_cnt;

    logic        en8;
    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_ready8;
    logic        out_bit8;
    logic        out_valid8;
    logic        word_done8;
    logic        frame_done8;
    logic        underrun8;
    logic [3:0]  bits_left8;
    logic [3:0]  pixel_cnt8;

    int n_checks;
    int n_fail;

    ws_pixel_serializer #(.W(24), .MSB_FIRST(1'b1), .PIXELS(2)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out_bit),
        .out_valid    (out_valid),
        .word_done    (word_done),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .bits_left_dbg(bits_left),
        .pixel_cnt_dbg(pixel_cnt)
    );

    ws_pixel_serializer #(.W(8), .MSB_FIRST(1'b0), .PIXELS(8)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .en           (en8),
        .in_data      (in_data8),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .out          (out_bit8),
        .out_valid    (out_valid8),
        .word_done    (word_done8),
        .frame_done   (frame_done8),
        .underrun     (underrun8),
        .bits_left_dbg(bits_left8),
        .pixel_cnt_dbg(pixel_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        en8       = 1'b0;
        in_valid8 = 1'b0;
        in_data8  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic accept_word(input logic [23:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Emit a full word already waiting in the hold buffer, MSB first.
    task automatic emit_word(input string tag, input logic [23:0] w, input logic exp_frame);
        en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("%s bit%0d", tag, k), 32'(out_bit), 32'(w[24-k]));
            check($sformatf("%s ovld%0d", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s left%0d", tag, k), 32'(bits_left), 32'(24 - k));
            check($sformatf("%s wdone%0d", tag, k), 32'(word_done), 32'(k == 24));
            check($sformatf("%s fdone%0d", tag, k), 32'(frame_done), 32'((k == 24) && exp_frame));
            check($sformatf("%s urun%0d", tag, k), 32'(underrun), 32'd0);
        end
        en = 1'b0;
    endtask

    initial begin
        logic [23:0] wa;
        logic [23:0] wb;
        logic [23:0] wc;
        logic [7:0]  d8;
        n_checks = 0;
        n_fail   = 0;

        // Reset state and a single MSB-first word.
        do_reset();
        check("rst out", 32'(out_bit), 32'd0);
        check("rst ovld", 32'(out_valid), 32'd0);
        check("rst left", 32'(bits_left), 32'd0);
        check("rst pcnt", 32'(pixel_cnt), 32'd0);
        check("rst ready", 32'(in_ready), 32'd1);
        check("rst pulses", 32'({word_done, frame_done, underrun}), 32'd0);
        wa = 24'hA50FC3;
        accept_word(wa);
        check("t1 ready_full", 32'(in_ready), 32'd0);
        emit_word("t1", wa, 1'b0);
        check("t1 pcnt", 32'(pixel_cnt), 32'd1);

        // Back-to-back words: second accepted after the first tick, no gap.
        do_reset();
        wa = 24'h5AC3F0;
        wb = 24'h81FF7E;
        accept_word(wa);
        in_data  = wb;
        in_valid = 1'b1;
        en       = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step();
            check($sformatf("t2 bit%0d", k), 32'(out_bit), k <= 24 ? 32'(wa[24-k]) : 32'(wb[48-k]));
            check($sformatf("t2 ovld%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("t2 left%0d", k), 32'(bits_left), k <= 24 ? 32'(24 - k) : 32'(48 - k));
            check($sformatf("t2 wdone%0d", k), 32'(word_done), 32'((k == 24) || (k == 48)));
            check($sformatf("t2 fdone%0d", k), 32'(frame_done), 32'(k == 48));
            check($sformatf("t2 pcnt%0d", k), 32'(pixel_cnt), 32'((k >= 24) && (k < 48)));
            check($sformatf("t2 ready%0d", k), 32'(in_ready), 32'((k == 1) || (k >= 25)));
            if (k == 2) in_valid = 1'b0;
        end
        en = 1'b0;

        // LSB-first 8-bit instance.
        do_reset();
        d8 = 8'h01;
        in_data8  = d8;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        en8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t3 bit%0d", k), 32'(out_bit8), 32'(d8[k-1]));
            check($sformatf("t3 ovld%0d", k), 32'(out_valid8), 32'd1);
            check($sformatf("t3 wdone%0d", k), 32'(word_done8), 32'(k == 8));
        end
        en8 = 1'b0;
        d8 = 8'hB4;
        in_data8  = d8;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        en8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t3b bit%0d", k), 32'(out_bit8), 32'(d8[k-1]));
        end
        en8 = 1'b0;
        check("t3b pcnt", 32'(pixel_cnt8), 32'd2);

        // Underrun mid-frame; a word accepted on the starved tick resumes the frame.
        do_reset();
        wa = 24'h123456;
        wb = 24'hFEDCBA;
        accept_word(wa);
        emit_word("t4a", wa, 1'b0);
        check("t4 pcnt1", 32'(pixel_cnt), 32'd1);
        in_data  = wb;
        in_valid = 1'b1;
        en       = 1'b1;
        step();
        in_valid = 1'b0;
        en       = 1'b0;
        check("t4 urun", 32'(underrun), 32'd1);
        check("t4 out0", 32'(out_bit), 32'd0);
        check("t4 ovld0", 32'(out_valid), 32'd0);
        check("t4 pcnt_hold", 32'(pixel_cnt), 32'd1);
        check("t4 wdone0", 32'(word_done), 32'd0);
        check("t4 ready", 32'(in_ready), 32'd0);
        emit_word("t4b", wb, 1'b1);
        check("t4 pcnt_wrap", 32'(pixel_cnt), 32'd0);

        // Hold full while en=0: in_valid ignored, outputs stable, held word wins.
        do_reset();
        wa = 24'hC0FFEE;
        wb = 24'h3C3C3C;
        wc = 24'hFFFFFF;
        accept_word(wa);
        en = 1'b1;
        step();
        en = 1'b0;
        check("t5 first", 32'(out_bit), 32'(wa[23]));
        accept_word(wb);
        in_data  = wc;
        in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("t5 ready%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("t5 out%0d", k), 32'(out_bit), 32'(wa[23]));
            check($sformatf("t5 ovld%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("t5 left%0d", k), 32'(bits_left), 32'd23);
            check($sformatf("t5 pulses%0d", k), 32'({word_done, frame_done, underrun}), 32'd0);
        end
        in_valid = 1'b0;
        en = 1'b1;
        for (int k = 2; k <= 24; k++) begin
            step();
            check($sformatf("t5a bit%0d", k), 32'(out_bit), 32'(wa[24-k]));
            check($sformatf("t5a wdone%0d", k), 32'(word_done), 32'(k == 24));
        end
        emit_word("t5b", wb, 1'b1);

        // Reset mid-word with the hold full.
        do_reset();
        wa = 24'h0F0F0F;
        wb = 24'hAAAAAA;
        wc = 24'h96E1B2;
        accept_word(wa);
        in_data  = wb;
        in_valid = 1'b1;
        en       = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
        end
        check("t6 pre_left", 32'(bits_left), 32'd14);
        check("t6 pre_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        check("t6 out", 32'(out_bit), 32'd0);
        check("t6 ovld", 32'(out_valid), 32'd0);
        check("t6 left", 32'(bits_left), 32'd0);
        check("t6 pcnt", 32'(pixel_cnt), 32'd0);
        check("t6 ready", 32'(in_ready), 32'd1);
        check("t6 pulses", 32'({word_done, frame_done, underrun}), 32'd0);
        rst      = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        accept_word(wc);
        emit_word("t6b", wc, 1'b0);
        check("t6 pcnt_end", 32'(pixel_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
